seq_mul_shift_add: RTL
======================

// Module: seq_mul_shift_add
// PURPOSE
//  Parametrised iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//  - Computes one partial product per clock under a start/busy/ready_out handshake.
//  - Replaces the single-cycle 4-bit load-and-multiply block in arithmetic datapaths.
//  - Trades latency for area: one adder of width WIDTH+1 instead of a full partial-product array.
// PARAMETERS
//  WIDTH  4  operand width in bits; legal values >= 2; product width is 2*WIDTH
// PORTS
//  clk        in   1        rising-edge clock
//  rst_a      in   1        asynchronous reset, active-high
//  start      in   1        request; sampled only in IDLE
//  a          in   WIDTH    multiplier; captured on the accepting edge
//  b          in   WIDTH    multiplicand; captured on the accepting edge
//  busy       out  1        high while in RUN
//  ready_out  out  1        one-cycle pulse: op holds a new product
//  op         out  2*WIDTH  product; holds its value until the next completion
// BEHAVIOUR
//  Reset: clk is clock; rst_a is asynchronous, active-high reset. On assertion: state=IDLE,
//   op=0, busy=0, ready_out=0, internal regs=0. Reset mid-RUN aborts the operation and op
//   is not updated with a partial result.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: when start=1 at edge k, latch a into mcand/mplier (b->mcand, a->mplier), clear acc
//    (WIDTH+1 bits) and cnt, go to RUN.
//   RUN: each edge, if mplier[0]=1 then {acc,mplier} = ({acc+mcand, mplier}) >> 1, else
//    {acc,mplier} >> 1; cnt++. After WIDTH iterations (edge k+WIDTH) load
//    op={acc,mplier}[2*WIDTH-1:0], set ready_out=1, go to DONE.
//   DONE: one cycle; ready_out deasserts and the FSM returns to IDLE at edge k+WIDTH+1.
//  Latency: start accepted at edge k -> op valid and ready_out=1 after edge k+WIDTH.
//   Minimum issue interval is WIDTH+2 cycles.
//  busy=1 exactly in RUN (after edge k through edge k+WIDTH).
//  start is ignored in RUN and DONE (no queueing); a/b changes after the accepting edge are ignored.
//  The acc adder is WIDTH+1 bits wide so the carry is never lost; no overflow is possible
//   since 2*WIDTH bits hold max (2^W-1)^2.
//  cnt width is $clog2(WIDTH+1) and cannot wrap within an operation.
//  All outputs are registered; there is no combinational path from input to output.
// CONFIGURATION
//  SEQ_MUL_SIGNED_EN defined:
//   - Adds input port signed_mode (1 bit, sampled with start).
//   - signed_mode=1: a and b are two's complement. Magnitudes are captured, and the result
//     sign (a[MSB]^b[MSB]) is registered.
//   - The final edge loads op with the 2's-complement negation when the sign is 1, so
//     latency is unchanged.
//   - The most-negative operands are handled: -2^(W-1) * -2^(W-1) = +2^(2W-2) fits.
//   - signed_mode=0: identical to the undefined build.
//  SEQ_MUL_SIGNED_EN undefined: unsigned only; no signed_mode port.
// TESTING
//  1. WIDTH=4: a=15, b=15, start pulse -> ready_out 4 edges later; op=8'hE1; busy high 4 cycles.
//  2. WIDTH=4: a=0, b=9, then a=9, b=0 -> op=8'h00 both times; ready_out pulses once per operation.
//  3. WIDTH=4: a=3, b=5 started; start held high with a=7, b=7 during RUN/DONE
//     -> op=8'h0F; second request accepted only on return to IDLE, then op=8'h31.
//  4. WIDTH=4: a=13, b=11 started; rst_a pulsed 2 cycles into RUN -> op=0, busy=0,
//     ready_out=0; no ready_out pulse follows.
//  5. WIDTH=8: a=255, b=255 -> op=16'hFE01 after 8 RUN cycles; randomised 1000-vector sweep
//     matches a*b.
//  6. SEQ_MUL_SIGNED_EN, WIDTH=4, signed_mode=1:
//     - a=-8, b=7 -> op=8'hC8 (-56)
//     - a=-8, b=-8 -> op=8'h40

Source files
------------

// File: rtl/seq_mul_shift_add_if.sv
// Handshake bundle for the iterative shift-add multiplier: start/a/b in, busy/ready_out/op out.
// The signed_mode request bit exists only when SEQ_MUL_SIGNED_EN is defined.
interface seq_mul_shift_add_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
`ifdef SEQ_MUL_SIGNED_EN
    logic                   signed_mode;
`endif
    logic                   busy;
    logic                   ready_out;
    logic [2*WIDTH-1:0]     op;

    modport master (
`ifdef SEQ_MUL_SIGNED_EN
        output signed_mode,
`endif
        output start, a, b,
        input  busy, ready_out, op
    );

    modport slave (
`ifdef SEQ_MUL_SIGNED_EN
        input  signed_mode,
`endif
        input  start, a, b,
        output busy, ready_out, op
    );
endinterface

// File: rtl/seq_mul_shift_add.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial product per clock.
// Define SEQ_MUL_SIGNED_EN to add two's-complement operation selected by signed_mode.
module seq_mul_shift_add #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_a,
    seq_mul_shift_add_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH:0]     acc_reg, acc_next;
    logic [WIDTH-1:0]   mplier_reg, mplier_next;
    logic [WIDTH-1:0]   mcand_reg, mcand_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] op_reg, op_next;
    logic               sign_reg, sign_next;
    logic               busy_reg, busy_next;
    logic               ready_reg, ready_next;

    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   a_cap, b_cap;
    logic               sign_cap;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     acc_shift;
    logic [WIDTH-1:0]   mplier_shift;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_final;

    assign accept    = (state_reg == IDLE) && bus.start;
    assign last_iter = (cnt_reg == CW'(WIDTH - 1));

    // Operands are reduced to magnitudes at capture so the shift-add core stays unsigned.
`ifdef SEQ_MUL_SIGNED_EN
    always_comb begin
        a_cap    = bus.a;
        b_cap    = bus.b;
        sign_cap = 1'b0;
        if (bus.signed_mode) begin
            if (bus.a[WIDTH-1]) a_cap = -bus.a;
            if (bus.b[WIDTH-1]) b_cap = -bus.b;
            sign_cap = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
    end
`else
    assign a_cap    = bus.a;
    assign b_cap    = bus.b;
    assign sign_cap = 1'b0;
`endif

    // One iteration: conditional add into acc, then shift {acc,mplier} right by one.
    assign sum       = mplier_reg[0] ? (acc_reg + {1'b0, mcand_reg}) : acc_reg;
    assign acc_shift = {1'b0, sum[WIDTH:1]};

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_mplier_shift
            assign mplier_shift[gi] = mplier_reg[gi + 1];
        end
    endgenerate
    assign mplier_shift[WIDTH-1] = sum[0];

    assign product       = {acc_shift[WIDTH-1:0], mplier_shift};
    assign product_final = sign_reg ? -product : product;

    // FSM state register
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // FSM outputs, registered so nothing reaches the ports combinationally
    always_comb begin
        busy_next  = (state_next == RUN);
        ready_next = (state_reg == RUN) && last_iter;
    end

    // Datapath next-state
    always_comb begin
        acc_next    = acc_reg;
        mplier_next = mplier_reg;
        mcand_next  = mcand_reg;
        cnt_next    = cnt_reg;
        sign_next   = sign_reg;
        op_next     = op_reg;
        if (accept) begin
            acc_next    = '0;
            mplier_next = a_cap;
            mcand_next  = b_cap;
            cnt_next    = '0;
            sign_next   = sign_cap;
        end else if (state_reg == RUN) begin
            acc_next    = acc_shift;
            mplier_next = mplier_shift;
            cnt_next    = cnt_reg + CW'(1);
            if (last_iter) op_next = product_final;
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            acc_reg    <= '0;
            mplier_reg <= '0;
            mcand_reg  <= '0;
            cnt_reg    <= '0;
            sign_reg   <= 1'b0;
            op_reg     <= '0;
            busy_reg   <= 1'b0;
            ready_reg  <= 1'b0;
        end else begin
            acc_reg    <= acc_next;
            mplier_reg <= mplier_next;
            mcand_reg  <= mcand_next;
            cnt_reg    <= cnt_next;
            sign_reg   <= sign_next;
            op_reg     <= op_next;
            busy_reg   <= busy_next;
            ready_reg  <= ready_next;
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.ready_out = ready_reg;
    assign bus.op        = op_reg;
endmodule
